// File: rtl/comparador_serial_id.sv
// Bit-serial unsigned magnitude comparator: one left-to-right comparator cell reused MSB-first.
// Optional build macro COMPARADOR_EARLY_EXIT_EN ends the scan as soon as the result is decided.
module comparador_serial_id #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             mayor,
    output logic             menor,
    output logic             igual
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] sa_reg;
    logic [WIDTH-1:0] sb_reg;
    logic             m_reg;
    logic             n_reg;
    logic [CW-1:0]    cnt_reg;

    logic a_bit;
    logic b_bit;
    logic m_next;
    logic n_next;
    logic last_step;

    assign a_bit = sa_reg[WIDTH-1];
    assign b_bit = sb_reg[WIDTH-1];

    // m: A>=B so far, n: A<=B so far; once one drops it stays latched.
    assign m_next = ~n_reg | (m_reg & (a_bit | ~b_bit));
    assign n_next = ~m_reg | (n_reg & (~a_bit | b_bit));

`ifdef COMPARADOR_EARLY_EXIT_EN
    assign last_step = (cnt_reg == CNT_ONE) || !(m_next && n_next);
`else
    assign last_step = (cnt_reg == CNT_ONE);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            sa_reg    <= '0;
            sb_reg    <= '0;
            m_reg     <= 1'b1;
            n_reg     <= 1'b1;
            cnt_reg   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mayor     <= 1'b0;
            menor     <= 1'b0;
            igual     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        sa_reg    <= A;
                        sb_reg    <= B;
                        m_reg     <= 1'b1;
                        n_reg     <= 1'b1;
                        cnt_reg   <= CNT_LOAD;
                        mayor     <= 1'b0;
                        menor     <= 1'b0;
                        igual     <= 1'b0;
                        busy      <= 1'b1;
                        state_reg <= SHIFT;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                SHIFT: begin
                    m_reg   <= m_next;
                    n_reg   <= n_next;
                    sa_reg  <= sa_reg << 1;
                    sb_reg  <= sb_reg << 1;
                    cnt_reg <= cnt_reg - CNT_ONE;
                    if (last_step) begin
                        mayor     <= m_next & ~n_next;
                        menor     <= ~m_next & n_next;
                        igual     <= m_next & n_next;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state_reg <= DONE;
                    end
                end
                default: begin
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_comparador_serial_id.sv
// Self-checking bench for comparador_serial_id: directed cases, back-to-back, reset abort and
// random sweeps at WIDTH=8 and WIDTH=2 against a plain unsigned-compare reference.
module tb_comparador_serial_id;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       start8, busy8, done8, mayor8, menor8, igual8;
    logic [7:0] a8, b8;
    logic       start2, busy2, done2, mayor2, menor2, igual2;
    logic [1:0] a2, b2;

    int checks   = 0;
    int failures = 0;

    comparador_serial_id #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .A(a8), .B(b8),
        .busy(busy8), .done(done8), .mayor(mayor8), .menor(menor8), .igual(igual8)
    );

    comparador_serial_id #(.WIDTH(2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .A(a2), .B(b2),
        .busy(busy2), .done(done2), .mayor(mayor2), .menor(menor2), .igual(igual2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference latency: full width, or position of first differing bit from the MSB when early exit is built in.
    function automatic int lat(input logic [7:0] a, input logic [7:0] b, input int w);
        if (a == b) return w;
`ifdef COMPARADOR_EARLY_EXIT_EN
        for (int i = w - 1; i >= 0; i--)
            if (a[i] != b[i]) return w - i;
`endif
        return w;
    endfunction

    task automatic drive(input int sel, input logic st, input logic [7:0] a, input logic [7:0] b);
        if (sel != 0) begin
            start2 = st; a2 = a[1:0]; b2 = b[1:0];
        end else begin
            start8 = st; a8 = a; b8 = b;
        end
    endtask

    function automatic logic [4:0] outs(input int sel);
        // {busy, done, mayor, menor, igual}
        if (sel != 0) return {busy2, done2, mayor2, menor2, igual2};
        return {busy8, done8, mayor8, menor8, igual8};
    endfunction

    function automatic logic mn_zero(input int sel);
        if (sel != 0) return !dut2.m_reg && !dut2.n_reg;
        return !dut8.m_reg && !dut8.n_reg;
    endfunction

    // Called at the negedge after the accepting edge; returns edges until done and busy-cycle count.
    task automatic wait_done(input int sel, output int k, output int busy_n, output bit got, output int mnbad);
        logic [4:0] o;
        k = 0; busy_n = 0; got = 1'b0; mnbad = 0;
        while (!got && k < 40) begin
            o = outs(sel);
            if (o[4]) busy_n++;
            if (mn_zero(sel)) mnbad++;
            @(posedge clk);
            k++;
            @(negedge clk);
            o = outs(sel);
            if (o[3]) got = 1'b1;
        end
        if (mn_zero(sel)) mnbad++;
    endtask

    task automatic do_cmp(input int sel, input logic [7:0] a_in, input logic [7:0] b_in, input string tag);
        int w, k, busy_n, mnbad, exp_lat;
        bit got;
        logic [7:0] a, b;
        logic [2:0] exp_res;
        logic [4:0] o;
        w = (sel != 0) ? 2 : 8;
        a = (sel != 0) ? {6'b0, a_in[1:0]} : a_in;
        b = (sel != 0) ? {6'b0, b_in[1:0]} : b_in;
        exp_lat = lat(a, b, w);
        exp_res = {a > b, a < b, a == b};
        @(negedge clk);
        drive(sel, 1'b1, a, b);
        @(posedge clk);
        @(negedge clk);
        drive(sel, 1'b0, 8'($urandom), 8'($urandom));
        wait_done(sel, k, busy_n, got, mnbad);
        o = outs(sel);
        check({tag, "_timeout"}, 32'(got), 32'd1);
        check({tag, "_latency"}, 32'(k), 32'(exp_lat));
        check({tag, "_busy_cycles"}, 32'(busy_n), 32'(exp_lat));
        check({tag, "_busy_at_done"}, 32'(o[4]), 32'd0);
        check({tag, "_result"}, 32'(o[2:0]), 32'(exp_res));
        check({tag, "_mn_00"}, 32'(mnbad), 32'd0);
        @(posedge clk);
        @(negedge clk);
        o = outs(sel);
        check({tag, "_done_pulse"}, 32'(o[3]), 32'd0);
        check({tag, "_result_hold"}, 32'(o[2:0]), 32'(exp_res));
        $display("txn %s w=%0d A=%0h B=%0h lat=%0d busy=%0d mayor/menor/igual=%03b", tag, w, a, b, k, busy_n, o[2:0]);
    endtask

    initial begin
        int k, k2, busy_n, mnbad, l1, l2, done_seen;
        bit got;
        logic [7:0] ra, rb;

        reset = 1'b1;
        drive(0, 1'b0, 8'h00, 8'h00);
        drive(1, 1'b0, 8'h00, 8'h00);
        #2;
        check("reset_outs8", 32'(outs(0)), 32'd0);
        check("reset_outs2", 32'(outs(1)), 32'd0);
        check("reset_mn8", 32'({dut8.m_reg, dut8.n_reg}), 32'd3);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("idle_outs8", 32'(outs(0)), 32'd0);

        do_cmp(0, 8'hA5, 8'hA5, "eq_a5");
        do_cmp(0, 8'h80, 8'h7F, "gt_80_7f");
        do_cmp(0, 8'h00, 8'h01, "lt_00_01");

        // Back-to-back with a mid-SHIFT start pulse that must be ignored.
        l1 = lat(8'h10, 8'h20, 8);
        l2 = lat(8'h30, 8'h20, 8);
        @(negedge clk);
        drive(0, 1'b1, 8'h10, 8'h20);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 8'h00, 8'h00);
        k = 0; got = 1'b0;
        while (!got && k < 40) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            if (done8) got = 1'b1;
            else if (k == 1) drive(0, 1'b1, 8'hFF, 8'h00);
            else drive(0, 1'b0, 8'hFF, 8'h00);
        end
        check("b2b_first_timeout", 32'(got), 32'd1);
        check("b2b_first_latency", 32'(k), 32'(l1));
        check("b2b_first_result", 32'({mayor8, menor8, igual8}), 32'b010);
        drive(0, 1'b1, 8'h30, 8'h20);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 8'h00, 8'h00);
        check("b2b_done_drop", 32'(done8), 32'd0);
        check("b2b_busy_again", 32'(busy8), 32'd1);
        wait_done(0, k2, busy_n, got, mnbad);
        check("b2b_second_timeout", 32'(got), 32'd1);
        check("b2b_spacing", 32'(k2 + 1), 32'(l2 + 1));
        check("b2b_second_result", 32'({mayor8, menor8, igual8}), 32'b100);
        $display("txn b2b first_lat=%0d spacing=%0d results=menor,mayor", k, k2 + 1);

        // Reset mid-comparison: outputs clear at once, no done afterwards.
        @(negedge clk);
        drive(0, 1'b1, 8'h55, 8'h54);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 8'h00, 8'h00);
        repeat (4) @(posedge clk);
        #2;
        check("pre_reset_busy", 32'(busy8), 32'd1);
        reset = 1'b1;
        #1;
        check("async_reset_outs", 32'(outs(0)), 32'd0);
        check("async_reset_mn", 32'({dut8.m_reg, dut8.n_reg}), 32'd3);
        @(negedge clk);
        reset = 1'b0;
        done_seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8 || busy8) done_seen++;
        end
        check("no_done_after_reset", 32'(done_seen), 32'd0);
        $display("txn reset_abort A=55 B=54 stray_activity=%0d", done_seen);
        do_cmp(0, 8'hFF, 8'hFE, "after_reset_ff_fe");

        // WIDTH=2 directed corners.
        do_cmp(1, 8'h3, 8'h3, "w2_eq");
        do_cmp(1, 8'h2, 8'h1, "w2_gt");
        do_cmp(1, 8'h0, 8'h1, "w2_lt");

        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = ($urandom_range(0, 9) == 0) ? ra : 8'($urandom);
            do_cmp(0, ra, rb, "rand8");
        end
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom_range(0, 3));
            rb = 8'($urandom_range(0, 3));
            do_cmp(1, ra, rb, "rand2");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/comparador_serial_id.md
Name: comparador_serial_id

Overview:
- Bit-serial magnitude comparator.
- Captures two WIDTH-bit unsigned words and feeds them MSB-first, one bit pair per clock, through the left-to-right comparator cell recurrence held in two state flip-flops (m, n).
- Reports A>B, A<B or A=B with a start/done handshake.
- Sits in the Izquierda-derecha comparator path as the sequential stage that supplies bit pairs to the cell and consumes its M/N outputs, replacing a WIDTH-cell combinational chain with one cell reused over time.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- A  input  WIDTH  operand A, unsigned; sampled on the accepting edge.
- B  input  WIDTH  operand B, unsigned; sampled on the accepting edge.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse; result valid.
- mayor  output  1  A>B.
- menor  output  1  A<B.
- igual  output  1  A=B.

Behaviour:
- Reset (asynchronous, immediate, any state, including mid-comparison):
  - State goes to IDLE.
  - m=1, n=1.
  - Shift registers and counter are cleared.
  - busy=0, done=0, mayor=0, menor=0, igual=0.
  - An in-flight comparison is discarded and never produces done.
- Cell recurrence, applied each SHIFT cycle to the current MSBs a, b:
  - m' = ~n | (m & (a | ~b))
  - n' = ~m | (n & (~a | b))
  - Meaning: m=1 means A>=B so far, n=1 means A<=B so far. (m,n)=(1,1) is equal, (1,0) is greater, (0,1) is less. (0,0) is unreachable; a bench assertion flags it.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at an edge: load sa<=A, sb<=B, m<=1, n<=1, cnt<=WIDTH; clear mayor/menor/igual to 0; go to SHIFT.
  - start=0: stay in IDLE, outputs hold.
- SHIFT:
  - Each edge: update m,n from sa[WIDTH-1], sb[WIDTH-1]; shift sa and sb left by 1 (zero fill); cnt<=cnt-1.
  - On the edge where cnt==1 (last bit), go to DONE. On that same edge, register mayor=m'&~n', menor=~m'&n', igual=m'&n', and done=1.
  - start is ignored in SHIFT. A and B may change freely in SHIFT without affecting the result.
- DONE:
  - Lasts exactly one cycle with done=1.
  - Next edge: done<=0. If start=1, accept new operands exactly as in IDLE and go to SHIFT (back-to-back operation). Otherwise go to IDLE.
- Latency: start accepted at edge E0; bits processed at edges E1..E_WIDTH; done high from E_WIDTH to E_WIDTH+1. Throughput is one comparison per WIDTH+1 cycles.
- Result hold: mayor/menor/igual hold the last result after done until the next start is accepted. Exactly one of them is 1 after a completed comparison.
- busy=1 exactly in SHIFT, i.e. for WIDTH cycles per comparison.
- Counter is $clog2(WIDTH+1) bits wide; it never wraps; all arithmetic is unsigned.

Optional Feature:
- Macro: COMPARADOR_EARLY_EXIT_EN.
- Defined:
  - In SHIFT, if the updated (m',n') != (1,1), go to DONE on that edge, register the result and pulse done, regardless of cnt.
  - Remaining bits are not examined; the result is identical to full evaluation.
  - busy duration is (index from MSB of the first differing bit)+1 cycles. Equal operands still take WIDTH cycles.
- Undefined: always WIDTH SHIFT cycles. Early-decided m,n stay latched by the recurrence, so the result is unchanged.

Test Plan:
- WIDTH=8, A=0xA5, B=0xA5, start pulse -> done exactly 8 edges after accept; igual=1, mayor=0, menor=0; busy high for 8 cycles.
- A=0x80, B=0x7F -> mayor=1, menor=0, igual=0. With COMPARADOR_EARLY_EXIT_EN: done 1 edge after accept, busy for 1 cycle.
- A=0x00, B=0x01 -> menor=1; done at edge 8 both with and without the macro (difference in LSB).
- Back-to-back: hold start=1 through DONE with A=0x10,B=0x20 then A=0x30,B=0x20 -> two done pulses 9 edges apart, results menor then mayor. A mid-SHIFT start pulse is ignored.
- reset asserted at edge 4 of a SHIFT -> all outputs 0 immediately, no done pulse. New start A=0xFF,B=0xFE -> mayor=1.
- Random sweep, 1000 pairs, WIDTH=8 and WIDTH=2 -> results match unsigned compare; one-hot results; (m,n)=(0,0) never seen.
